// File: rtl/conv_pkg.sv
// Shared definitions for the convolution matrix loader: default geometry,
// loader state encoding and the bit-plane-major flattening rule.
package conv_pkg;

    localparam int unsigned DEF_ROW_LIMIT   = 10;
    localparam int unsigned DEF_WINDOW_SIZE = 3;
    localparam int unsigned DEF_DATA_W      = 5;

    typedef enum logic [1:0] {
        KERNEL,
        IMAGE,
        PRESENT,
        RESYNC
    } loader_state_t;

    // Bit b of element k sits in plane b, so its flat position is b*N + k.
    function automatic int unsigned bitplane_index(input int unsigned b,
                                                   input int unsigned k,
                                                   input int unsigned n);
        return b * n + k;
    endfunction

endpackage

// File: rtl/bitplane_writer.sv
// Slot-addressed element store exposed as a flattened bit-plane-major bus.
// Each element bit goes to its own plane; a write touches only the addressed slot.
module bitplane_writer
    import conv_pkg::*;
#(
    parameter int unsigned N      = 9,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IDX_W  = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wrEn,
    input  logic [IDX_W-1:0]      slot,
    input  logic [DATA_W-1:0]     elem,
    output logic [DATA_W*N-1:0]   planes
);

    for (genvar b = 0; b < DATA_W; b++) begin : g_plane
        logic [N-1:0] plane;

        // Plane storage: cleared only by reset, overwritten slot by slot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                plane <= '0;
            end else if (wrEn) begin
                plane[slot] <= elem[b];
            end
        end

        assign planes[bitplane_index(b, 0, N) +: N] = plane;
    end

endmodule

// File: rtl/conv_matrix_loader.sv
// Stream-to-matrix front end: collects kernel then image elements from a
// valid/ready stream, scatters them into bit-plane buses and presents both
// buses under a valid/ready handshake. Framing errors pulse frame_err.
module conv_matrix_loader
    import conv_pkg::*;
#(
    parameter int unsigned ROW_LIMIT   = DEF_ROW_LIMIT,
    parameter int unsigned WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int unsigned DATA_W      = DEF_DATA_W
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     s_valid,
    output logic                                     s_ready,
    input  logic [DATA_W-1:0]                        s_data,
    input  logic                                     s_last,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic [DATA_W*ROW_LIMIT*ROW_LIMIT-1:0]    in_matrix,
    output logic [DATA_W*WINDOW_SIZE*WINDOW_SIZE-1:0] eigen_matrix,
    output logic                                     frame_err
);

    localparam int unsigned N_IMG = ROW_LIMIT * ROW_LIMIT;
    localparam int unsigned N_KER = WINDOW_SIZE * WINDOW_SIZE;
    localparam int unsigned N_MAX = (N_IMG > N_KER) ? N_IMG : N_KER;
    localparam int unsigned CNT_W = $clog2(N_MAX);
    localparam int unsigned IMG_W = $clog2(N_IMG);
    localparam int unsigned KER_W = $clog2(N_KER);

    loader_state_t     stateQ, stateD;
    logic [CNT_W-1:0]  elemCnt, cntD;
    logic              sReadyQ, mValidQ, errQ, errD;
    logic              kerWe, imgWe, accept;

    assign accept    = s_valid && sReadyQ;
    assign s_ready   = sReadyQ;
    assign m_valid   = mValidQ;
    assign frame_err = errQ;

    // Next-state, element counter and write enables for the frame parser.
    always_comb begin
        stateD = stateQ;
        cntD   = elemCnt;
        errD   = 1'b0;
        kerWe  = 1'b0;
        imgWe  = 1'b0;
        unique case (stateQ)
            KERNEL: begin
                if (accept) begin
                    kerWe = 1'b1;
                    if (s_last) begin
                        // Frame ended inside the kernel: restart collection.
                        errD   = 1'b1;
                        stateD = KERNEL;
                        cntD   = '0;
                    end else if (elemCnt == CNT_W'(N_KER - 1)) begin
                        stateD = IMAGE;
                        cntD   = '0;
                    end else begin
                        cntD = elemCnt + CNT_W'(1);
                    end
                end
            end
            IMAGE: begin
                if (accept) begin
                    imgWe = 1'b1;
                    if (elemCnt == CNT_W'(N_IMG - 1)) begin
                        cntD = '0;
                        if (s_last) begin
                            stateD = PRESENT;
                        end else begin
                            // Sender overran the frame: drop until its s_last.
                            errD   = 1'b1;
                            stateD = RESYNC;
                        end
                    end else if (s_last) begin
                        errD   = 1'b1;
                        stateD = KERNEL;
                        cntD   = '0;
                    end else begin
                        cntD = elemCnt + CNT_W'(1);
                    end
                end
            end
            PRESENT: begin
                if (m_ready) begin
                    stateD = KERNEL;
                    cntD   = '0;
                end
            end
            RESYNC: begin
                if (accept && s_last) begin
                    stateD = KERNEL;
                    cntD   = '0;
                end
            end
            default: begin
                stateD = KERNEL;
                cntD   = '0;
            end
        endcase
    end

    // State, counter and registered handshake/error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= KERNEL;
            elemCnt <= '0;
            sReadyQ <= 1'b0;
            mValidQ <= 1'b0;
            errQ    <= 1'b0;
        end else begin
            stateQ  <= stateD;
            elemCnt <= cntD;
            sReadyQ <= (stateD != PRESENT);
            mValidQ <= (stateD == PRESENT);
            errQ    <= errD;
        end
    end

    bitplane_writer #(
        .N      (N_KER),
        .DATA_W (DATA_W),
        .IDX_W  (KER_W)
    ) u_kernel (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrEn   (kerWe),
        .slot   (elemCnt[KER_W-1:0]),
        .elem   (s_data),
        .planes (eigen_matrix)
    );

    bitplane_writer #(
        .N      (N_IMG),
        .DATA_W (DATA_W),
        .IDX_W  (IMG_W)
    ) u_image (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrEn   (imgWe),
        .slot   (elemCnt[IMG_W-1:0]),
        .elem   (s_data),
        .planes (in_matrix)
    );

endmodule

// File: tb/tb_conv_matrix_loader.sv
// Bench for conv_matrix_loader: table of frame scenarios plus hand-written
// timing sequences; presented matrices are checked against a packing model.
module tb_conv_matrix_loader;

    localparam int ROW_LIMIT   = 10;
    localparam int WINDOW_SIZE = 3;
    localparam int DATA_W      = 5;
    localparam int N_IMG       = 100;
    localparam int N_KER       = 9;
    localparam int IMG_BITS    = DATA_W * N_IMG;
    localparam int KER_BITS    = DATA_W * N_KER;

    logic                clk, rst_n, s_valid, s_ready, s_last, m_valid, m_ready, frame_err;
    logic [DATA_W-1:0]   s_data;
    logic [IMG_BITS-1:0] in_matrix;
    logic [KER_BITS-1:0] eigen_matrix;

    conv_matrix_loader #(
        .ROW_LIMIT   (ROW_LIMIT),
        .WINDOW_SIZE (WINDOW_SIZE),
        .DATA_W      (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .in_matrix    (in_matrix),
        .eigen_matrix (eigen_matrix),
        .frame_err    (frame_err)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } elem_t;

    typedef struct {
        logic [IMG_BITS-1:0] im;
        logic [KER_BITS-1:0] ke;
    } exp_t;

    typedef struct {
        int kerLastAt;   // -1: full kernel
        int imgLastAt;   // index carrying s_last, -1: none
        int junkN;       // trailing junk elements, s_last on the last one
        int seed;
        int expErr;
        int expPresent;
    } vec_t;

    int total = 0, passed = 0, cyc = 0;
    int errCount = 0, presentCount = 0, goodSent = 0;
    logic [DATA_W-1:0] ker [N_KER];
    logic [DATA_W-1:0] img [N_IMG];
    elem_t stream [$];
    exp_t  sb [$];
    vec_t  vecs [9];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b, required %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [511:0] act,
                             input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [IMG_BITS-1:0] model_img();
        logic [IMG_BITS-1:0] r;
        r = '0;
        for (int b = 0; b < DATA_W; b++)
            for (int k = 0; k < N_IMG; k++) r[b*N_IMG+k] = img[k][b];
        return r;
    endfunction

    function automatic logic [KER_BITS-1:0] model_ker();
        logic [KER_BITS-1:0] r;
        r = '0;
        for (int b = 0; b < DATA_W; b++)
            for (int k = 0; k < N_KER; k++) r[b*N_KER+k] = ker[k][b];
        return r;
    endfunction

    task automatic fill(input int seed);
        for (int k = 0; k < N_KER; k++) ker[k] = DATA_W'((k * 3 + seed) % 32);
        for (int k = 0; k < N_IMG; k++) img[k] = DATA_W'((k * 7 + seed) % 32);
    endtask

    task automatic build_frame(input int kerLastAt, input int imgLastAt, input int junkN);
        elem_t e;
        int nImg;
        stream.delete();
        if (kerLastAt >= 0) begin
            for (int k = 0; k <= kerLastAt; k++) begin
                e.d = ker[k]; e.l = (k == kerLastAt); stream.push_back(e);
            end
        end else begin
            for (int k = 0; k < N_KER; k++) begin
                e.d = ker[k]; e.l = 1'b0; stream.push_back(e);
            end
            nImg = (imgLastAt >= 0) ? imgLastAt + 1 : N_IMG;
            for (int k = 0; k < nImg; k++) begin
                e.d = img[k]; e.l = (k == imgLastAt); stream.push_back(e);
            end
            for (int j = 0; j < junkN; j++) begin
                e.d = DATA_W'((j * 11 + 5) % 32); e.l = (j == junkN - 1); stream.push_back(e);
            end
            if (imgLastAt == N_IMG - 1) begin
                exp_t x;
                x.im = model_img();
                x.ke = model_ker();
                sb.push_back(x);
                goodSent++;
            end
        end
    endtask

    // Drive one element and hold it until the edge that accepts it.
    task automatic push_elem(input logic [DATA_W-1:0] d, input logic l, input int gapPct);
        logic rdy;
        int guard;
        if (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = d; s_last = l;
        guard = 0;
        do begin
            rdy = s_ready;
            @(posedge clk); #1;
            guard++;
        end while (!rdy && guard < 2000);
        if (!rdy) begin
            total++;
            $display("FAIL accept_timeout: s_ready stayed %b, required 1", s_ready);
        end
    endtask

    task automatic send_stream(input int gapPct);
        foreach (stream[i]) push_elem(stream[i].d, stream[i].l, gapPct);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic settle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: frame_err pulse width and scoreboard compare at each handshake.
    initial begin : monitor
        logic prevErr;
        exp_t e;
        prevErr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevErr = 1'b0;
            end else begin
                if (frame_err) begin
                    errCount++;
                    check_bit("frame_err_one_cycle", prevErr, 1'b0);
                end
                prevErr = frame_err;
                if (m_valid && m_ready) begin
                    presentCount++;
                    check_int("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_vec("in_matrix", 512'(in_matrix), 512'(e.im));
                        check_vec("eigen_matrix", 512'(eigen_matrix), 512'(e.ke));
                    end
                end
            end
        end
    end

    initial begin : stim
        int relCyc, c0, e0, p0;
        logic [IMG_BITS-1:0] expImg;
        logic [KER_BITS-1:0] expKer;

        vecs[0] = '{kerLastAt: -1, imgLastAt: 99, junkN: 0, seed: 3,  expErr: 0, expPresent: 1};
        vecs[1] = '{kerLastAt: -1, imgLastAt: 50, junkN: 0, seed: 4,  expErr: 1, expPresent: 0};
        vecs[2] = '{kerLastAt: -1, imgLastAt: 99, junkN: 0, seed: 7,  expErr: 0, expPresent: 1};
        vecs[3] = '{kerLastAt: -1, imgLastAt: -1, junkN: 3, seed: 9,  expErr: 1, expPresent: 0};
        vecs[4] = '{kerLastAt: -1, imgLastAt: 99, junkN: 0, seed: 11, expErr: 0, expPresent: 1};
        vecs[5] = '{kerLastAt: 4,  imgLastAt: -1, junkN: 0, seed: 12, expErr: 1, expPresent: 0};
        vecs[6] = '{kerLastAt: -1, imgLastAt: 99, junkN: 0, seed: 13, expErr: 0, expPresent: 1};
        vecs[7] = '{kerLastAt: -1, imgLastAt: 0,  junkN: 0, seed: 14, expErr: 1, expPresent: 0};
        vecs[8] = '{kerLastAt: -1, imgLastAt: 99, junkN: 0, seed: 17, expErr: 0, expPresent: 1};

        rst_n = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        #1 rst_n = 1'b0;
        #21;
        check_vec("rst_in_matrix", 512'(in_matrix), 512'(0));
        check_vec("rst_eigen_matrix", 512'(eigen_matrix), 512'(0));
        check_bit("rst_m_valid", m_valid, 1'b0);
        check_bit("rst_frame_err", frame_err, 1'b0);
        check_bit("rst_s_ready", s_ready, 1'b0);

        // Nominal frame straight out of reset, s_valid continuously high.
        @(posedge clk); #1;
        rst_n = 1'b1;
        relCyc = cyc;
        check_bit("s_ready_before_first_edge", s_ready, 1'b0);
        for (int k = 0; k < N_KER; k++) ker[k] = DATA_W'(k + 1);
        for (int k = 0; k < N_IMG; k++) img[k] = DATA_W'(k % 32);
        build_frame(-1, 99, 0);
        send_stream(0);
        check_int("nominal_mvalid_edge", cyc - relCyc, 110);
        check_bit("nominal_m_valid", m_valid, 1'b1);
        check_bit("nominal_s_ready_low", s_ready, 1'b0);
        check_bit("ker_bit_0", eigen_matrix[0*9+0], 1'b1);
        check_bit("ker_bit_10", eigen_matrix[1*9+1], 1'b1);
        check_bit("img_bit_431", in_matrix[4*100+31], 1'b1);
        check_bit("img_bit_415", in_matrix[4*100+15], 1'b0);
        @(posedge clk); #1;
        check_bit("nominal_m_valid_fall", m_valid, 1'b0);
        check_bit("nominal_s_ready_rise", s_ready, 1'b1);

        // Backpressure: hold m_ready low with s_valid asserted during PRESENT.
        m_ready = 1'b0;
        fill(21);
        build_frame(-1, 99, 0);
        expImg = model_img();
        expKer = model_ker();
        send_stream(0);
        s_valid = 1'b1; s_data = '1; s_last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check_bit("bp_m_valid", m_valid, 1'b1);
            check_bit("bp_s_ready", s_ready, 1'b0);
            @(posedge clk); #1;
        end
        check_vec("bp_in_matrix", 512'(in_matrix), 512'(expImg));
        check_vec("bp_eigen_matrix", 512'(eigen_matrix), 512'(expKer));
        check_int("bp_no_err", errCount, 0);
        m_ready = 1'b1;
        @(posedge clk); #1;
        check_bit("bp_m_valid_fall", m_valid, 1'b0);
        check_bit("bp_s_ready_rise", s_ready, 1'b1);
        c0 = cyc;
        fill(22);
        build_frame(-1, 99, 0);
        send_stream(0);
        check_int("bp_next_frame_edge", cyc - c0, 109);
        settle(3);

        // Asynchronous reset in the middle of the image.
        fill(30);
        build_frame(-1, 99, 0);
        sb.pop_back();
        goodSent--;
        stream = stream[0:N_KER+39];
        send_stream(0);
        s_valid = 1'b1; s_data = img[40]; s_last = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_vec("midrst_in_matrix", 512'(in_matrix), 512'(0));
        check_vec("midrst_eigen_matrix", 512'(eigen_matrix), 512'(0));
        check_bit("midrst_m_valid", m_valid, 1'b0);
        check_bit("midrst_s_ready", s_ready, 1'b0);
        check_bit("midrst_frame_err", frame_err, 1'b0);
        s_valid = 1'b0;
        @(posedge clk); #1;
        check_bit("midrst_s_ready_held", s_ready, 1'b0);
        rst_n = 1'b1;
        check_bit("midrst_s_ready_release", s_ready, 1'b0);
        @(posedge clk); #1;
        check_bit("midrst_s_ready_edge", s_ready, 1'b1);

        // Scenario table: well-formed and malformed frames.
        for (int i = 0; i < 9; i++) begin
            e0 = errCount;
            p0 = presentCount;
            fill(vecs[i].seed);
            build_frame(vecs[i].kerLastAt, vecs[i].imgLastAt, vecs[i].junkN);
            send_stream(0);
            settle(4);
            check_int($sformatf("vec%0d_frame_err", i), errCount - e0, vecs[i].expErr);
            check_int($sformatf("vec%0d_present", i), presentCount - p0, vecs[i].expPresent);
        end

        // Random frames with idle gaps on s_valid.
        e0 = errCount;
        for (int f = 0; f < 50; f++) begin
            for (int k = 0; k < N_KER; k++) ker[k] = DATA_W'($urandom_range(31));
            for (int k = 0; k < N_IMG; k++) img[k] = DATA_W'($urandom_range(31));
            build_frame(-1, 99, 0);
            send_stream(30);
        end
        settle(5);
        check_int("random_no_err", errCount - e0, 0);

        check_int("sb_drained", sb.size(), 0);
        check_int("present_total", presentCount, goodSent);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
